// File: rtl/sig_pkg.sv
// Shared constants and state encoding for the signature match controller.
package sig_pkg;

   localparam int unsigned DATA_W    = 64;
   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned SIG_DEPTH = 63;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned STATE_W   = 3;

   localparam logic [STATE_W-1:0] ENC_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ENC_SCAN   = 3'd1;
   localparam logic [STATE_W-1:0] ENC_DRAIN  = 3'd2;
   localparam logic [STATE_W-1:0] ENC_RESULT = 3'd3;
   localparam logic [STATE_W-1:0] ENC_CLEAR  = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = ENC_IDLE,
      ST_SCAN   = ENC_SCAN,
      ST_DRAIN  = ENC_DRAIN,
      ST_RESULT = ENC_RESULT,
      ST_CLEAR  = ENC_CLEAR
   } state_t;

   // Address of the last stored entry; only meaningful for a non-zero count.
   function automatic logic [ADDR_W-1:0] last_idx(input logic [ADDR_W-1:0] count);
      return count - ADDR_W'(1);
   endfunction

endpackage

// File: rtl/sig_match_ctrl.sv
// Sequences signature loads into the signature memory and scans it for each packet
// word, returning hit/miss and the index of the first matching entry.
module sig_match_ctrl
   import sig_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] pkt_data,
   output logic              pkt_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_hit,
   output logic [ADDR_W-1:0] res_idx,
   output logic [ADDR_W-1:0] sig_count,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wr_en,
   output logic              mem_rst,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_full
);

   state_t            state;
   logic [DATA_W-1:0] pkt_q;
   logic              cmp_pend;
   logic [ADDR_W-1:0] cmp_idx;

   logic              idle;
   logic              at_cap;
   logic              ld_acc;
   logic              pkt_acc;
   logic              match;
   logic              scan_last;

   // Handshakes are decided in the same cycle so an accepted word reaches the memory at once.
   assign idle      = (state == ST_IDLE) & ~rst;
   assign at_cap    = (sig_count == ADDR_W'(SIG_DEPTH));
   assign ld_ready  = idle & ~clr & ~mem_full & ~at_cap;
   assign pkt_ready = idle & ~clr & ~ld_valid;
   assign ld_acc    = ld_valid & ld_ready;
   assign pkt_acc   = pkt_valid & pkt_ready;

   assign mem_wr_en = ld_acc;
   assign mem_din   = ld_acc ? ld_data : '0;
   assign mem_rst   = rst | (state == ST_CLEAR);

   // cmp_pend/cmp_idx describe the read issued last cycle, whose data is on mem_dout now.
   assign match     = cmp_pend & (mem_dout == pkt_q);
   assign scan_last = (mem_rd_addr == last_idx(sig_count));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pkt_q       <= '0;
         cmp_pend    <= 1'b0;
         cmp_idx     <= '0;
         res_valid   <= 1'b0;
         res_hit     <= 1'b0;
         res_idx     <= '0;
         sig_count   <= '0;
         hit_cnt     <= '0;
         mem_rd_addr <= '0;
         mem_rd_en   <= 1'b0;
      end else if (clr) begin
         // Abort everything; the memory itself is wiped while in CLEAR.
         state       <= ST_CLEAR;
         cmp_pend    <= 1'b0;
         cmp_idx     <= '0;
         res_valid   <= 1'b0;
         res_hit     <= 1'b0;
         res_idx     <= '0;
         sig_count   <= '0;
         hit_cnt     <= '0;
         mem_rd_addr <= '0;
         mem_rd_en   <= 1'b0;
      end else begin
         cmp_pend <= mem_rd_en;
         cmp_idx  <= mem_rd_addr;

         if (ld_acc) begin
            sig_count <= sig_count + ADDR_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (pkt_acc) begin
                  pkt_q <= pkt_data;
                  if (sig_count == '0) begin
                     state     <= ST_RESULT;
                     res_valid <= 1'b1;
                     res_hit   <= 1'b0;
                     res_idx   <= '0;
                  end else begin
                     state       <= ST_SCAN;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= '0;
                  end
               end
            end

            ST_SCAN: begin
               if (match) begin
                  state     <= ST_RESULT;
                  mem_rd_en <= 1'b0;
                  res_valid <= 1'b1;
                  res_hit   <= 1'b1;
                  res_idx   <= cmp_idx;
                  hit_cnt   <= hit_cnt + CNT_W'(1);
               end else if (scan_last) begin
                  state     <= ST_DRAIN;
                  mem_rd_en <= 1'b0;
               end else begin
                  mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
               end
            end

            ST_DRAIN: begin
               // Final compare against the last entry read.
               state     <= ST_RESULT;
               res_valid <= 1'b1;
               res_hit   <= match;
               res_idx   <= match ? cmp_idx : '0;
               if (match) begin
                  hit_cnt <= hit_cnt + CNT_W'(1);
               end
            end

            ST_RESULT: begin
               if (res_ready) begin
                  state     <= ST_IDLE;
                  res_valid <= 1'b0;
                  res_hit   <= 1'b0;
                  res_idx   <= '0;
               end
            end

            ST_CLEAR: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sig_match_ctrl.sv
// Randomized self-checking bench for sig_match_ctrl with a behavioural signature-memory model.
module tb_sig_match_ctrl;
   import sig_pkg::*;

   logic              clk = 1'b0;
   logic              rst, clr, ld_valid, pkt_valid, res_ready;
   logic [DATA_W-1:0] ld_data, pkt_data;
   logic              ld_ready, pkt_ready, res_valid, res_hit;
   logic [ADDR_W-1:0] res_idx, sig_count, mem_rd_addr;
   logic [CNT_W-1:0]  hit_cnt;
   logic [DATA_W-1:0] mem_din, mem_dout;
   logic              mem_wr_en, mem_rst, mem_rd_en, mem_full;

   int total = 0;
   int bad   = 0;

   // Reference state: stored signatures in load order and the expected hit counter.
   logic [63:0] ref_q[$];
   logic [63:0] ld_list[$];
   int          exp_hit_cnt = 0;

   // Signature memory: sequential writes, one-cycle read latency, full at 63 entries.
   logic [63:0] mem_arr [64];
   int unsigned wcnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rst) wcnt <= 0;
      else if (mem_wr_en && wcnt < 63) begin
         mem_arr[wcnt] <= mem_din;
         wcnt          <= wcnt + 1;
      end
      if (mem_rd_en) mem_dout <= mem_arr[mem_rd_addr];
   end
   assign mem_full = (wcnt == 63);

   sig_match_ctrl dut (
      .clk(clk), .rst(rst), .clr(clr),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx),
      .sig_count(sig_count), .hit_cnt(hit_cnt),
      .mem_din(mem_din), .mem_wr_en(mem_wr_en), .mem_rst(mem_rst),
      .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_dout(mem_dout), .mem_full(mem_full)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic load_burst(input string tag);
      bit exp_rdy;
      logic [63:0] w;
      foreach (ld_list[i]) begin
         w = ld_list[i];
         ld_valid = 1'b1;
         ld_data  = w;
         @(negedge clk);
         exp_rdy = (ref_q.size() < 63);
         total++;
         if (ld_ready !== exp_rdy) begin
            bad++; $display("FAIL %s ld_ready word %0d got=%b exp=%b", tag, i, ld_ready, exp_rdy);
         end
         total++;
         if (mem_wr_en !== exp_rdy || (exp_rdy && mem_din !== w)) begin
            bad++; $display("FAIL %s write word %0d wr_en=%b din=%h exp_en=%b exp_din=%h",
                            tag, i, mem_wr_en, mem_din, exp_rdy, w);
         end
         if (exp_rdy) ref_q.push_back(w);
         next_cycle();
      end
      ld_valid = 1'b0;
      ld_list.delete();
      @(negedge clk);
      total++;
      if (sig_count !== ADDR_W'(ref_q.size())) begin
         bad++; $display("FAIL %s sig_count got=%0d exp=%0d", tag, sig_count, ref_q.size());
      end
      next_cycle();
   endtask

   task automatic start_pkt(input logic [63:0] w, input string tag);
      pkt_valid = 1'b1;
      pkt_data  = w;
      @(negedge clk);
      total++;
      if (pkt_ready !== 1'b1) begin
         bad++; $display("FAIL %s pkt_ready got=%b exp=1", tag, pkt_ready);
      end
      next_cycle();
      pkt_valid = 1'b0;
      pkt_data  = rnd64();
   endtask

   // Sends one packet, checks latency, read count and result, stalls res_ready, then completes.
   task automatic send_pkt(input logic [63:0] w, input int stall, input string tag);
      int n, exp_idx, exp_lat, exp_rd, lat, rd;
      bit exp_hit;
      n = ref_q.size();
      exp_hit = 0;
      exp_idx = 0;
      foreach (ref_q[i]) if (!exp_hit && ref_q[i] == w) begin exp_hit = 1; exp_idx = i; end
      if (exp_hit) begin
         exp_lat = exp_idx + 3;
         exp_rd  = (exp_idx + 2 < n) ? exp_idx + 2 : n;
         exp_hit_cnt++;
      end else begin
         exp_lat = (n == 0) ? 1 : n + 2;
         exp_rd  = n;
      end
      res_ready = 1'b0;
      start_pkt(w, tag);
      rd = 0;
      for (lat = 1; lat < 300; lat++) begin
         @(negedge clk);
         if (res_valid === 1'b1) break;
         if (mem_rd_en === 1'b1) rd++;
         next_cycle();
      end
      total++;
      if (lat != exp_lat) begin
         bad++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat);
      end
      total++;
      if (res_hit !== exp_hit || res_idx !== ADDR_W'(exp_idx)) begin
         bad++; $display("FAIL %s result hit=%b idx=%0d exp_hit=%b exp_idx=%0d",
                         tag, res_hit, res_idx, exp_hit, exp_idx);
      end
      total++;
      if (rd != exp_rd) begin
         bad++; $display("FAIL %s read pulses got=%0d exp=%0d", tag, rd, exp_rd);
      end
      total++;
      if (hit_cnt !== CNT_W'(exp_hit_cnt)) begin
         bad++; $display("FAIL %s hit_cnt got=%0d exp=%0d", tag, hit_cnt, exp_hit_cnt);
      end
      for (int s = 0; s < stall; s++) begin
         next_cycle();
         @(negedge clk);
         total++;
         if (res_valid !== 1'b1 || res_hit !== exp_hit || res_idx !== ADDR_W'(exp_idx) ||
             pkt_ready !== 1'b0 || ld_ready !== 1'b0 || hit_cnt !== CNT_W'(exp_hit_cnt)) begin
            bad++; $display("FAIL %s stall %0d valid=%b hit=%b idx=%0d pkt_rdy=%b ld_rdy=%b hit_cnt=%0d exp_hit_cnt=%0d",
                            tag, s, res_valid, res_hit, res_idx, pkt_ready, ld_ready, hit_cnt, exp_hit_cnt);
         end
      end
      res_ready = 1'b1;
      next_cycle();
      res_ready = 1'b0;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0 || pkt_ready !== 1'b1 || hit_cnt !== CNT_W'(exp_hit_cnt)) begin
         bad++; $display("FAIL %s after handshake valid=%b pkt_ready=%b hit_cnt=%0d exp_hit_cnt=%0d",
                         tag, res_valid, pkt_ready, hit_cnt, exp_hit_cnt);
      end
      next_cycle();
   endtask

   task automatic do_clr(input string tag);
      clr = 1'b1;
      @(negedge clk);
      total++;
      if (ld_ready !== 1'b0 || pkt_ready !== 1'b0) begin
         bad++; $display("FAIL %s ready in clr cycle ld=%b pkt=%b exp=0", tag, ld_ready, pkt_ready);
      end
      next_cycle();
      clr = 1'b0;
      ref_q.delete();
      exp_hit_cnt = 0;
      @(negedge clk);
      total++;
      if (mem_rst !== 1'b1 || sig_count !== '0 || hit_cnt !== '0 || res_valid !== 1'b0) begin
         bad++; $display("FAIL %s clear cycle mem_rst=%b sig_count=%0d hit_cnt=%0d res_valid=%b",
                         tag, mem_rst, sig_count, hit_cnt, res_valid);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (mem_rst !== 1'b0 || pkt_ready !== 1'b1) begin
         bad++; $display("FAIL %s after clear mem_rst=%b pkt_ready=%b exp 0/1", tag, mem_rst, pkt_ready);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; res_ready = 1'b0;
      ld_valid = 1'b1; ld_data = '1; pkt_valid = 1'b1; pkt_data = '0;
      repeat (2) next_cycle();
      @(negedge clk);
      total++;
      if (mem_rst !== 1'b1) begin bad++; $display("FAIL reset mem_rst got=%b exp=1", mem_rst); end
      total++;
      if (ld_ready !== 1'b0 || pkt_ready !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
         bad++; $display("FAIL reset handshakes ld=%b pkt=%b wr=%b rd=%b exp all 0",
                         ld_ready, pkt_ready, mem_wr_en, mem_rd_en);
      end
      total++;
      if (res_valid !== 1'b0 || sig_count !== '0 || hit_cnt !== '0) begin
         bad++; $display("FAIL reset state res_valid=%b sig_count=%0d hit_cnt=%0d exp 0",
                         res_valid, sig_count, hit_cnt);
      end
      next_cycle();
      rst = 1'b0; ld_valid = 1'b0; pkt_valid = 1'b0;
      ref_q.delete();
      exp_hit_cnt = 0;
      @(negedge clk);
      total++;
      if (mem_rst !== 1'b0 || ld_ready !== 1'b1 || pkt_ready !== 1'b1) begin
         bad++; $display("FAIL reset release mem_rst=%b ld_ready=%b pkt_ready=%b exp 0/1/1",
                         mem_rst, ld_ready, pkt_ready);
      end
      next_cycle();
   endtask

   task automatic test_empty();
      send_pkt(rnd64(), 0, "empty");
   endtask

   task automatic test_load_hit(output logic [63:0] a, output logic [63:0] b, output logic [63:0] c);
      a = rnd64(); b = rnd64(); c = rnd64();
      ld_list.push_back(a); ld_list.push_back(b); ld_list.push_back(c);
      load_burst("load3");
      send_pkt(b, 0, "hit_b");
   endtask

   task automatic test_miss();
      send_pkt(rnd64(), 0, "miss_z");
   endtask

   task automatic test_stall(input logic [63:0] c);
      send_pkt(c, 5, "stall_c");
   endtask

   task automatic test_back_to_back(input logic [63:0] a);
      send_pkt(a, 0, "b2b_a");
      send_pkt(a, 1, "b2b_a2");
   endtask

   task automatic test_clear_mid_scan();
      int k;
      do_clr("pre_clr");
      for (int i = 0; i < 40; i++) ld_list.push_back(rnd64());
      load_burst("load40");
      start_pkt(ref_q[30], "clr_scan");
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (mem_rd_en === 1'b1 && mem_rd_addr === ADDR_W'(10)) break;
         next_cycle();
      end
      total++;
      if (k == 100) begin bad++; $display("FAIL clr_scan addr10 never read got=timeout exp=read"); end
      next_cycle();
      do_clr("clr_scan");
      k = 0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid === 1'b1) k++;
         next_cycle();
      end
      total++;
      if (k != 0) begin bad++; $display("FAIL clr_scan res_valid cycles got=%0d exp=0", k); end
   endtask

   task automatic test_reset_mid_scan();
      int k;
      for (int i = 0; i < 5; i++) ld_list.push_back(rnd64());
      load_burst("load5");
      start_pkt(rnd64(), "rst_scan");
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      ref_q.delete();
      exp_hit_cnt = 0;
      @(negedge clk);
      total++;
      if (pkt_ready !== 1'b1 || sig_count !== '0 || hit_cnt !== '0) begin
         bad++; $display("FAIL rst_scan pkt_ready=%b sig_count=%0d hit_cnt=%0d exp 1/0/0",
                         pkt_ready, sig_count, hit_cnt);
      end
      k = 0;
      repeat (15) begin
         next_cycle();
         @(negedge clk);
         if (res_valid === 1'b1) k++;
      end
      total++;
      if (k != 0) begin bad++; $display("FAIL rst_scan res_valid cycles got=%0d exp=0", k); end
      next_cycle();
   endtask

   task automatic test_fill();
      do_clr("fill_clr");
      for (int i = 0; i < 70; i++) ld_list.push_back(rnd64());
      load_burst("fill70");
      @(negedge clk);
      total++;
      if (ref_q.size() != 63 || mem_full !== 1'b1 || ld_ready !== 1'b0) begin
         bad++; $display("FAIL fill stored=%0d mem_full=%b ld_ready=%b exp 63/1/0",
                         ref_q.size(), mem_full, ld_ready);
      end
      next_cycle();
      send_pkt(ref_q[62], 0, "fill_hit62");
   endtask

   task automatic test_random();
      int r, nw;
      do_clr("rand_clr");
      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) begin
               if (ref_q.size() > 0 && $urandom_range(0, 3) == 0)
                  ld_list.push_back(ref_q[$urandom_range(0, ref_q.size() - 1)]);
               else
                  ld_list.push_back(rnd64());
            end
            load_burst("rand_load");
         end else if (r == 3) begin
            do_clr("rand_clr");
         end else if (ref_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            send_pkt(ref_q[$urandom_range(0, ref_q.size() - 1)], $urandom_range(0, 3), "rand_hit");
         end else begin
            send_pkt(rnd64(), $urandom_range(0, 3), "rand_any");
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] a, b, c;
      test_reset();
      test_empty();
      test_load_hit(a, b, c);
      test_miss();
      test_stall(c);
      test_back_to_back(a);
      test_clear_mid_scan();
      test_reset_mid_scan();
      test_fill();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
